input_demux: RTL and testbench

INPUT_DEMUX -- requirements
Module: input_demux

---
 rtl/input_demux.sv | 146 ++++++++++++++
 tb/tb_input_demux.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_demux.sv
// input_demux: one-input, N-output flit demultiplexer.
//
// An accepted flit lands in a one-entry stage register. On the next cycle it is
// either moved into the 2-entry FIFO of its destination port or, when the
// destination index is out of range, discarded and counted in drop_cnt.
// A stage flit whose FIFO is full (and not popping) stalls the whole input
// (head-of-line blocking).
//
// Ports
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   data_in    incoming flit payload
//   dest_in    destination port index for data_in
//   valid_in   data_in/dest_in valid
//   ready_out  block accepts a flit this cycle
//   data_out   per-port head-of-FIFO flit (meaningless while valid_out[i]=0)
//   valid_out  per-port FIFO not empty
//   ready_in   per-port downstream ready
//   drop_cnt   saturating count of flits discarded for an illegal destination

module input_demux #(
  parameter int unsigned N      = 16,
  parameter int unsigned WIDTH  = 329,
  parameter int unsigned DEST_W = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [WIDTH-1:0]  data_out [N-1:0],
  output logic [N-1:0]      valid_out,
  input  logic [N-1:0]      ready_in,
  output logic [15:0]       drop_cnt
);

  // ---------------------------------------------------------------------------
  // Input stage
  // ---------------------------------------------------------------------------
  logic              r_stage_valid;
  logic [WIDTH-1:0]  r_stage_data;
  logic [DEST_W-1:0] r_stage_dest;

  logic              w_dest_legal;
  logic [N-1:0]      w_sel;       // one-hot of stage dest, all-zero if illegal
  logic [N-1:0]      w_full;
  logic [N-1:0]      w_pop;
  logic [N-1:0]      w_push;
  logic              w_can_take;
  logic              w_dispatch;
  logic              w_drop;
  logic              w_accept;

  assign w_dest_legal = (32'(r_stage_dest) < N);

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sel[i] = (32'(r_stage_dest) == i);
    end
  end

  // A full FIFO still takes the stage flit if it pops in the same cycle.
  assign w_can_take = |(w_sel & (~w_full | w_pop));

  assign w_dispatch = r_stage_valid & w_dest_legal & w_can_take;
  assign w_drop     = r_stage_valid & ~w_dest_legal;
  assign w_push     = w_sel & {N{w_dispatch}};

  // Gated by RST_N so ready_out drops immediately on reset assertion and rises
  // in the very first cycle after release.
  assign ready_out = RST_N & (~r_stage_valid | w_dispatch | w_drop);
  assign w_accept  = valid_in & ready_out;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stage_valid <= 1'b0;
    end else if (w_accept) begin
      r_stage_valid <= 1'b1;
    end else if (w_dispatch || w_drop) begin
      r_stage_valid <= 1'b0;
    end
  end

  // Payload and destination carry no reset; they are qualified by r_stage_valid.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_stage_data <= data_in;
      r_stage_dest <= dest_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port 2-entry FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_port
    logic [1:0]       r_cnt;
    logic             r_wptr;
    logic             r_rptr;
    logic [WIDTH-1:0] r_mem [2];

    assign valid_out[i] = (r_cnt != 2'd0);
    assign w_full[i]    = (r_cnt == 2'd2);
    assign w_pop[i]     = valid_out[i] & ready_in[i];
    assign data_out[i]  = r_mem[r_rptr];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_cnt  <= 2'd0;
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
      end else begin
        if (w_push[i]) begin
          r_wptr <= ~r_wptr;
        end
        if (w_pop[i]) begin
          r_rptr <= ~r_rptr;
        end
        r_cnt <= r_cnt + 2'(w_push[i]) - 2'(w_pop[i]);
      end
    end

    always_ff @(posedge CLK) begin
      if (w_push[i]) begin
        r_mem[r_wptr] <= r_stage_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter, saturating at all-ones
  // ---------------------------------------------------------------------------
  logic [15:0] r_drop_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_input_demux.sv
module tb_input_demux;

  localparam int unsigned NP  = 16;
  localparam int unsigned W   = 329;
  localparam int unsigned DW  = 6;
  localparam int unsigned NP2 = 12;
  localparam int unsigned W2  = 8;
  localparam int unsigned DW2 = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST_N;
  logic [W-1:0]  data_in;
  logic [DW-1:0] dest_in;
  logic          valid_in;
  logic          ready_out;
  logic [W-1:0]  data_out [NP-1:0];
  logic [NP-1:0] valid_out;
  logic [NP-1:0] ready_in;
  logic [15:0]   drop_cnt;

  // Second instance with N=12 for the illegal-destination boundary.
  logic [W2-1:0]  data2;
  logic [DW2-1:0] dest2;
  logic           valid2;
  logic           ready_out2;
  logic [W2-1:0]  data_out2 [NP2-1:0];
  logic [NP2-1:0] valid_out2;
  logic [NP2-1:0] ready_in2;
  logic [15:0]    drop_cnt2;

  input_demux #(.N(NP), .WIDTH(W), .DEST_W(DW)) u_dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .data_in   (data_in),
    .dest_in   (dest_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .drop_cnt  (drop_cnt)
  );

  input_demux #(.N(NP2), .WIDTH(W2), .DEST_W(DW2)) u_dut12 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .data_in   (data2),
    .dest_in   (dest2),
    .valid_in  (valid2),
    .ready_out (ready_out2),
    .data_out  (data_out2),
    .valid_out (valid_out2),
    .ready_in  (ready_in2),
    .drop_cnt  (drop_cnt2)
  );

  typedef struct packed {
    logic [W-1:0] d;
    int unsigned  c;
  } exp_t;

  exp_t        exp_q [NP][$];
  exp_t        mon_e;
  exp_t        push_e;
  int          checks = 0;
  int          failures = 0;
  int unsigned ncyc = 0;
  bit          chk_lat = 1'b0;

  function automatic logic [W-1:0] mk(input int unsigned tag);
    logic [W-1:0] v;
    v = '0;
    v[31:0]     = tag;
    v[W-1 -: 32] = ~tag;
    return v;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++) begin
      if (exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [DW-1:0] d, input logic [W-1:0] v, input bit must_rdy);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    dest_in  = d;
    data_in  = v;
    valid_in = 1'b1;
    while (!got && n < 50) begin
      @(negedge CLK);
      if (n == 0 && must_rdy) chk("ready_out_high", W'(ready_out), W'(1));
      if (ready_out) got = 1'b1;
      n++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: dest %0d not accepted in 50 cycles, required acceptance", d);
    end
    @(posedge CLK);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!all_empty() && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checks++;
    if (!all_empty()) begin
      failures++;
      $display("FAIL drain_timeout: flits still expected after 200 cycles, required none");
    end
  endtask

  initial begin
    RST_N     = 1'b0;
    data_in   = '0;
    dest_in   = '0;
    valid_in  = 1'b0;
    ready_in  = '1;
    data2     = '0;
    dest2     = '0;
    valid2    = 1'b0;
    ready_in2 = '1;

    // Scoreboard monitor: pushes at acceptance, pops whenever a port transfers.
    fork
      forever begin
        @(negedge CLK);
        ncyc++;
        if (!RST_N) begin
          for (int i = 0; i < NP; i++) exp_q[i].delete();
        end else begin
          for (int i = 0; i < NP; i++) begin
            if (valid_out[i] && ready_in[i]) begin
              checks++;
              if (exp_q[i].size() == 0) begin
                failures++;
                $display("FAIL unexpected_out: port %0d got %0h, required no flit", i,
                         data_out[i]);
              end else begin
                mon_e = exp_q[i].pop_front();
                chk("data_order", data_out[i], mon_e.d);
                if (chk_lat) chk("latency", W'(ncyc), W'(mon_e.c));
              end
            end
          end
          if (valid_in && ready_out && (32'(dest_in) < NP)) begin
            push_e.d = data_in;
            push_e.c = ncyc + 2;
            exp_q[dest_in].push_back(push_e);
          end
        end
      end
    join_none

    // Reset state, no clock edge needed
    #3;
    chk("rst_ready_out", W'(ready_out), W'(0));
    chk("rst_valid_out", W'(valid_out), W'(0));
    chk("rst_drop_cnt", W'(drop_cnt), W'(0));
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_reset", W'(ready_out), W'(1));
    @(posedge CLK);
    #1;

    // Streaming D0..D15 to ports 0..15
    chk_lat = 1'b1;
    for (int unsigned k = 0; k < NP; k++) send(DW'(k), mk(k), 1'b1);
    wait_drain();
    chk_lat = 1'b0;

    // Backpressure on port 3
    ready_in[3] = 1'b0;
    send(DW'(3), mk(100), 1'b1);
    send(DW'(3), mk(101), 1'b1);
    send(DW'(3), mk(102), 1'b1);
    dest_in  = DW'(3);
    data_in  = mk(103);
    valid_in = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("hol_block_ready", W'(ready_out), W'(0));
      chk("hol_block_valid3", W'(valid_out[3]), W'(1));
    end
    @(posedge CLK);
    #1;
    ready_in[3] = 1'b1;
    send(DW'(3), mk(103), 1'b1);
    wait_drain();

    // Full FIFO 5 with simultaneous pop and push
    ready_in[5] = 1'b0;
    send(DW'(5), mk(200), 1'b1);
    send(DW'(5), mk(201), 1'b1);
    send(DW'(5), mk(202), 1'b1);
    ready_in[5] = 1'b1;
    send(DW'(5), mk(203), 1'b1);
    ready_in[5] = 1'b0;
    @(negedge CLK);
    chk("full_after_pop_push", W'(ready_out), W'(0));
    chk("full_valid5", W'(valid_out[5]), W'(1));
    @(posedge CLK);
    #1;
    ready_in[5] = 1'b1;
    wait_drain();

    // Illegal destination on the N=12 instance
    chk("dut12_drop_init", W'(drop_cnt2), W'(0));
    dest2  = DW2'(13);
    data2  = 8'hA5;
    valid2 = 1'b1;
    @(negedge CLK);
    chk("dut12_ready", W'(ready_out2), W'(1));
    @(posedge CLK);
    #1;
    valid2 = 1'b0;
    @(negedge CLK);
    chk("dut12_no_valid_a", W'(valid_out2), W'(0));
    @(posedge CLK);
    #1;
    chk("dut12_drop_13", W'(drop_cnt2), W'(1));
    chk("dut12_no_valid_b", W'(valid_out2), W'(0));
    dest2  = DW2'(12);
    valid2 = 1'b1;
    @(posedge CLK);
    #1;
    valid2 = 1'b0;
    @(posedge CLK);
    #1;
    chk("dut12_drop_12", W'(drop_cnt2), W'(2));
    dest2  = DW2'(11);
    data2  = 8'h3C;
    valid2 = 1'b1;
    @(posedge CLK);
    #1;
    valid2 = 1'b0;
    @(negedge CLK);
    chk("dut12_lat_stage", W'(valid_out2), W'(0));
    @(negedge CLK);
    chk("dut12_valid11", W'(valid_out2), W'(12'h800));
    chk("dut12_data11", W'(data_out2[11]), W'(8'h3C));
    chk("dut12_drop_keep", W'(drop_cnt2), W'(2));
    @(posedge CLK);
    #1;

    // Illegal destination and saturation on the main instance
    send(DW'(16), mk(300), 1'b1);
    chk("drop_not_yet", W'(drop_cnt), W'(0));
    @(posedge CLK);
    #1;
    chk("drop_dest16", W'(drop_cnt), W'(1));
    send(DW'(63), mk(301), 1'b1);
    @(posedge CLK);
    #1;
    chk("drop_dest63", W'(drop_cnt), W'(2));
    dest_in  = DW'(40);
    data_in  = mk(302);
    valid_in = 1'b1;
    repeat (65532) @(posedge CLK);
    #1;
    valid_in = 1'b0;
    @(posedge CLK);
    #1;
    chk("drop_fffe", W'(drop_cnt), W'(16'hFFFE));
    send(DW'(40), mk(303), 1'b1);
    @(posedge CLK);
    #1;
    chk("drop_ffff", W'(drop_cnt), W'(16'hFFFF));
    send(DW'(40), mk(304), 1'b1);
    @(posedge CLK);
    #1;
    chk("drop_saturate", W'(drop_cnt), W'(16'hFFFF));

    // Reset mid-operation: FIFOs 0 and 7 occupied, stage holding a flit
    ready_in[0] = 1'b0;
    ready_in[7] = 1'b0;
    send(DW'(0), mk(400), 1'b1);
    send(DW'(7), mk(401), 1'b1);
    send(DW'(7), mk(402), 1'b1);
    send(DW'(7), mk(403), 1'b1);
    chk("stall_before_reset", W'(ready_out), W'(0));
    chk("occupied_before_reset", W'(valid_out), W'(16'h0081));
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_valid_out", W'(valid_out), W'(0));
    chk("async_rst_ready_out", W'(ready_out), W'(0));
    chk("async_rst_drop_cnt", W'(drop_cnt), W'(0));
    ready_in = '1;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_mid_reset", W'(ready_out), W'(1));
    repeat (5) @(posedge CLK);
    #1;
    chk("nothing_after_reset", W'(valid_out), W'(0));
    chk("drop_after_reset", W'(drop_cnt), W'(0));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
